md_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.

---
 rtl/md_unit_if.sv | 16 +
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// The pipeline drives operands and the start pulse; the unit returns busy and HI/LO.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.
// The result is computed at start, held pending for the op latency, then committed.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  // Full-width products: sign- or zero-extend to 2*WIDTH before multiplying.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // Signed divide on magnitudes so most-negative / -1 wraps cleanly instead of overflowing.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, q_sgn, r_sgn;
  assign a_neg = bus.a[WIDTH-1];
  assign b_neg = bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_sgn = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r_sgn = a_neg ? -r_mag : r_mag;

  logic b_zero;
  assign b_zero = (bus.b == '0);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (bus.op == OP_MULT) ? prod_s : prod_u;
              cnt_d   = CW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero re-commits the current HI/LO, i.e. leaves them unchanged.
              if (b_zero) begin
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
              end else if (bus.op == OP_DIV) begin
                pend_hi_d = r_sgn;
                pend_lo_d = q_sgn;
              end else begin
                pend_hi_d = bus.a % bus.b;
                pend_lo_d = bus.a / bus.b;
              end
              cnt_d   = CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against a
// cycle-count reference model that computes results with 64-bit integer arithmetic.
module tb_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W)) bus();
  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: absolute edge counter and the edge at which the in-flight op commits.
  longint      cyc     = 0;
  longint      done_at = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_keep = 1'b0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_edge(bit r, bit s, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int          sa, sb;
    longint      la, lb, q, rm;
    logic [63:0] prod;
    cyc++;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    if (r) begin
      m_hi = '0; m_lo = '0; done_at = 0;
    end else if (done_at >= cyc) begin
      if (cyc == done_at && !p_keep) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (s) begin
      case (op)
        3'd0: begin
          prod = la * lb;
          {p_hi, p_lo} = prod; p_keep = 1'b0; done_at = cyc + MC;
        end
        3'd1: begin
          prod = {32'b0, a} * {32'b0, b};
          {p_hi, p_lo} = prod; p_keep = 1'b0; done_at = cyc + MC;
        end
        3'd2: begin
          p_keep = (b == 0);
          if (!p_keep) begin
            q = la / lb; rm = la % lb;
            p_lo = q[31:0]; p_hi = rm[31:0];
          end
          done_at = cyc + DC;
        end
        3'd3: begin
          p_keep = (b == 0);
          if (!p_keep) begin p_lo = a / b; p_hi = a % b; end
          done_at = cyc + DC;
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic step(bit r, bit s, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    rst = r; bus.start = s; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    model_edge(r, s, op, a, b);
    #1;
    check($sformatf("busy@%0d", cyc), {63'b0, bus.busy}, {63'b0, (cyc < done_at)});
    check($sformatf("hi@%0d", cyc), {32'b0, bus.hi}, {32'b0, m_hi});
    check($sformatf("lo@%0d", cyc), {32'b0, bus.lo}, {32'b0, m_lo});
  endtask

  // Idle cycles scramble a/b to confirm operands are only sampled at start.
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return 32'(0 - $urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    step(1'b1, 1'b0, 3'd0, 0, 0);
    step(1'b1, 1'b1, 3'd4, 32'h1234, 0);
    check("reset_hi", {32'b0, bus.hi}, 64'h0);
    check("reset_lo", {32'b0, bus.lo}, 64'h0);
    check("reset_busy", {63'b0, bus.busy}, 64'h0);

    step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5); idle(MC);
    check("mult_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'b0, bus.lo}, 64'hFFFF_FFF1);

    step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2); idle(MC);
    check("multu_hi", {32'b0, bus.hi}, 64'h1);
    check("multu_lo", {32'b0, bus.lo}, 64'hFFFF_FFFE);

    step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2); idle(DC);
    check("div_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);
    check("div_lo", {32'b0, bus.lo}, 64'hFFFF_FFFD);
    step(1'b0, 1'b1, 3'd3, 32'd7, 32'd2); idle(DC);
    check("divu_hi", {32'b0, bus.hi}, 64'h1);
    check("divu_lo", {32'b0, bus.lo}, 64'h3);

    step(1'b0, 1'b1, 3'd4, 32'h11, 0);
    step(1'b0, 1'b1, 3'd5, 32'h22, 0);
    step(1'b0, 1'b1, 3'd3, 32'd7, 32'd0); idle(DC);
    check("div0_hi", {32'b0, bus.hi}, 64'h11);
    check("div0_lo", {32'b0, bus.lo}, 64'h22);

    step(1'b0, 1'b1, 3'd0, 32'd2, 32'd3);
    step(1'b0, 1'b1, 3'd5, 32'd99, 0);
    step(1'b0, 1'b1, 3'd2, 32'd50, 32'd7);
    idle(MC - 2);
    check("ignore_hi", {32'b0, bus.hi}, 64'h0);
    check("ignore_lo", {32'b0, bus.lo}, 64'h6);
    check("ignore_busy", {63'b0, bus.busy}, 64'h0);

    step(1'b0, 1'b1, 3'd2, 32'd100, 32'd7); idle(3);
    step(1'b1, 1'b0, 3'd0, 0, 0);
    check("abort_hi", {32'b0, bus.hi}, 64'h0);
    check("abort_lo", {32'b0, bus.lo}, 64'h0);
    idle(DC);

    step(1'b0, 1'b1, 3'd4, 32'h5A5A, 0);
    step(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF); idle(DC);
    check("minneg_hi", {32'b0, bus.hi}, 64'h0);
    check("minneg_lo", {32'b0, bus.lo}, 64'h8000_0000);
    step(1'b0, 1'b1, 3'd6, 32'hDEAD, 32'hBEEF);
    step(1'b0, 1'b1, 3'd7, 32'hDEAD, 32'hBEEF);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
           3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
